// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants, state type and note base-divisor table for the note oscillator
package synth_pkg;

   localparam int CNT_W        = 19;
   localparam int NOTE_W       = 4;
   localparam int OCT_W        = 3;
   localparam int FINE_W       = 4;
   localparam int DETUNE_SHIFT = 9;

   localparam logic [CNT_W-1:0]  MIN_DIV  = 2;
   localparam logic [CNT_W-1:0]  MAX_DIV  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
   localparam logic [NOTE_W-1:0] REST_MIN = 12;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } osc_state_t;

   // Clocks per period at 12 MHz for C1..B1, rounded to the nearest clock
   function automatic logic [CNT_W-1:0] base_div(input logic [NOTE_W-1:0] note);
      case (note)
         4'd0:    return 19'd366972;
         4'd1:    return 19'd346320;
         4'd2:    return 19'd326886;
         4'd3:    return 19'd308563;
         4'd4:    return 19'd291262;
         4'd5:    return 19'd274914;
         4'd6:    return 19'd259459;
         4'd7:    return 19'd244898;
         4'd8:    return 19'd231169;
         4'd9:    return 19'd218182;
         4'd10:   return 19'd205938;
         4'd11:   return 19'd194363;
         default: return '0;
      endcase
   endfunction

   function automatic logic is_rest(input logic [NOTE_W-1:0] note);
      return note >= REST_MIN;
   endfunction

endpackage

// File: rtl/note_divisor_lut.sv
// rtl/note_divisor_lut.sv - combinational note/octave(/fine) to clocks-per-period divisor; DETUNE_EN adds fine tuning
module note_divisor_lut
   import synth_pkg::*;
(
   input  logic [NOTE_W-1:0]        note,
   input  logic [OCT_W-1:0]         octave,
`ifdef DETUNE_EN
   input  logic signed [FINE_W-1:0] fine,
`endif
   output logic [CNT_W-1:0]         div
);

   logic [CNT_W-1:0] shifted;
   logic [CNT_W-1:0] clamped;

   // Octave shift of the base period, never allowed below a two-clock period
   always_comb begin
      shifted = base_div(note) >> octave;
      clamped = (shifted < MIN_DIV) ? MIN_DIV : shifted;
   end

`ifdef DETUNE_EN
   localparam int SUM_W = CNT_W + 3;

   logic [CNT_W-1:0]        coarse;
   logic signed [SUM_W-1:0] step;
   logic signed [SUM_W-1:0] sum;

   // Each fine step moves the period by div/512 clocks; result clamped to the counter range
   always_comb begin
      coarse = clamped >> DETUNE_SHIFT;
      step   = $signed({{(SUM_W-FINE_W){fine[FINE_W-1]}}, fine}) * $signed({3'b000, coarse});
      sum    = $signed({3'b000, clamped}) + step;
      if (sum < $signed({3'b000, MIN_DIV})) begin
         div = MIN_DIV;
      end else if (sum > $signed({3'b000, MAX_DIV})) begin
         div = MAX_DIV;
      end else begin
         div = sum[CNT_W-1:0];
      end
   end
`else
   assign div = clamped;
`endif

endmodule

// File: rtl/note_oscillator.sv
// rtl/note_oscillator.sv - phase counter oscillator with pending note slot and glitch-free pitch changes; DETUNE_EN adds fine_i
module note_oscillator
   import synth_pkg::*;
(
   input  logic                     clk,
   input  logic                     Rst_i,
   input  logic                     note_valid,
   output logic                     note_ready,
   input  logic [NOTE_W-1:0]        note_i,
   input  logic [OCT_W-1:0]         octave_i,
`ifdef DETUNE_EN
   input  logic signed [FINE_W-1:0] fine_i,
`endif
   input  logic                     gate_i,
   output logic [CNT_W-1:0]         count,
   output logic [CNT_W-1:0]         divisor,
   output logic                     wrap_o,
   output logic                     active_o
);

   osc_state_t        state;
   logic              slot_full;
   logic [NOTE_W-1:0] slot_note;
   logic [OCT_W-1:0]  slot_oct;
   logic [CNT_W-1:0]  lut_div;
   logic              accept;
   logic              at_wrap;
   logic              slot_rest;

`ifdef DETUNE_EN
   logic signed [FINE_W-1:0] slot_fine;
`endif

   assign note_ready = ~slot_full;
   assign accept     = note_valid && note_ready;
   assign at_wrap    = (count == (divisor - CNT_ONE));
   assign slot_rest  = is_rest(slot_note);

   // Divisor is always computed from the pending slot so a change lands only when the slot is consumed
   note_divisor_lut u_lut (
      .note   (slot_note),
      .octave (slot_oct),
`ifdef DETUNE_EN
      .fine   (slot_fine),
`endif
      .div    (lut_div)
   );

`ifdef DETUNE_EN
   // Fine offset travels with the note it was accepted alongside
   always_ff @(posedge clk or posedge Rst_i) begin
      if (Rst_i) begin
         slot_fine <= '0;
      end else if (accept) begin
         slot_fine <= fine_i;
      end
   end
`endif

   // Oscillator FSM, pending slot and phase counter; pitch and stop decisions only at count wrap
   always_ff @(posedge clk or posedge Rst_i) begin
      if (Rst_i) begin
         state     <= IDLE;
         slot_full <= 1'b0;
         slot_note <= '0;
         slot_oct  <= '0;
         count     <= '0;
         divisor   <= '0;
         wrap_o    <= 1'b0;
         active_o  <= 1'b0;
      end else begin
         wrap_o <= 1'b0;
         if (accept) begin
            slot_full <= 1'b1;
            slot_note <= note_i;
            slot_oct  <= octave_i;
         end
         case (state)
            IDLE: begin
               count <= '0;
               if (slot_full) begin
                  slot_full <= 1'b0;
                  if (!slot_rest) begin
                     divisor  <= lut_div;
                     active_o <= 1'b1;
                     state    <= RUN;
                  end
               end
            end
            RUN, DRAIN: begin
               if (at_wrap) begin
                  count  <= '0;
                  wrap_o <= 1'b1;
                  if (state == DRAIN) begin
                     divisor  <= '0;
                     active_o <= 1'b0;
                     state    <= IDLE;
                  end else if (slot_full) begin
                     slot_full <= 1'b0;
                     if (slot_rest) begin
                        divisor  <= '0;
                        active_o <= 1'b0;
                        state    <= IDLE;
                     end else begin
                        divisor <= lut_div;
                        if (!gate_i) begin
                           state <= DRAIN;
                        end
                     end
                  end else if (!gate_i) begin
                     state <= DRAIN;
                  end
               end else begin
                  count <= count + CNT_ONE;
                  if (state == RUN && !gate_i && !(slot_full && slot_rest)) begin
                     state <= DRAIN;
                  end else if (state == DRAIN && gate_i) begin
                     state <= RUN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_oscillator.sv
// tb/tb_note_oscillator.sv - scoreboard bench for note_oscillator with a period-level reference model
module tb_note_oscillator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        note_valid = 1'b0;
   logic        note_ready;
   logic [3:0]  note = '0;
   logic [2:0]  octave = '0;
   logic        gate = 1'b1;
   logic [18:0] count;
   logic [18:0] divisor;
   logic        wrap;
   logic        active;
`ifdef DETUNE_EN
   logic signed [3:0] fine = '0;
`endif

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int cur_exp = 0;

   real freq [12] = '{32.70, 34.65, 36.71, 38.89, 41.20, 43.65,
                      46.25, 49.00, 51.91, 55.00, 58.27, 61.74};

   note_oscillator dut (
      .clk        (clk),
      .Rst_i      (rst),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_i     (note),
      .octave_i   (octave),
`ifdef DETUNE_EN
      .fine_i     (fine),
`endif
      .gate_i     (gate),
      .count      (count),
      .divisor    (divisor),
      .wrap_o     (wrap),
      .active_o   (active)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int model_div(input int n, input int o, input int f);
      int d;
      if (n >= 12) return 0;
      d = $rtoi(12.0e6 / freq[n] + 0.5);
      d = d / (2 ** o);
      if (d < 2) d = 2;
      d = d + f * (d / 512);
      if (d < 2) d = 2;
      if (d > 524287) d = 524287;
      return d;
   endfunction

   function automatic int rand_fine();
`ifdef DETUNE_EN
      return int'($urandom_range(15, 0)) - 8;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int b = 0;
      while (!note_ready && b < 20000) begin tick(1); b++; end
      if (!note_ready) check(name, note_ready, 1);
   endtask

   task automatic wait_count(input int target, input string name);
      int b = 0;
      while (count != target && b < 20000) begin tick(1); b++; end
      if (count != target) check(name, count, target);
   endtask

   task automatic wait_inactive(input string name);
      int b = 0;
      while (active && b < 20000) begin tick(1); b++; end
      if (active) check(name, active, 0);
   endtask

   task automatic send_note(input int n, input int o, input int f, input bit track);
      int d;
      wait_ready("ready_timeout");
      if (!note_ready) return;
      note   = n[3:0];
      octave = o[2:0];
`ifdef DETUNE_EN
      fine   = f[3:0];
`endif
      note_valid = 1'b1;
      @(posedge clk);
      #1;
      note_valid = 1'b0;
      if (track) begin
         d = model_div(n, o, f);
         if (d != cur_exp) begin
            exp_q.push_back(d);
            cur_exp = d;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      cur_exp = 0;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   // Monitor: divisor changes are popped from the scoreboard; every wrap closes a period that is measured
   int prev_div = 0;
   int period_len = 0;
   int period_max = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_div   = 0;
         period_len = 0;
         period_max = 0;
      end else begin
         if (int'(divisor) != prev_div) begin
            if (exp_q.size() == 0) check("unexpected_divisor_change", divisor, prev_div);
            else check("divisor_sequence", divisor, exp_q.pop_front());
            check("change_at_count0", count, 0);
         end
         if (wrap) begin
            check("period_length", period_len, prev_div);
            check("period_max_count", period_max, prev_div - 1);
         end
         if (count == 0) begin
            period_len = 1;
            period_max = 0;
         end else begin
            period_len++;
            if (int'(count) > period_max) period_max = count;
         end
         prev_div = divisor;
      end
   end

   initial begin
      int n, o, f;
      int b;
      tick(3);
      check("reset_count", count, 0);
      check("reset_divisor", divisor, 0);
      check("reset_wrap", wrap, 0);
      check("reset_active", active, 0);
      check("reset_ready", note_ready, 1);
      rst = 1'b0;
      tick(2);

      // Low C: load timing and counting, then reset with a note pending
      send_note(0, 0, 0, 1);
      check("ready_low_after_accept", note_ready, 0);
      tick(1);
      check("c0_divisor", divisor, 366972);
      check("c0_active", active, 1);
      check("ready_after_consume", note_ready, 1);
      tick(50);
      check("c0_count", count, 50);
      send_note(9, 3, 0, 0);
      check("pending_ready_low", note_ready, 0);
      rst = 1'b1;
      #1;
      check("rst_count", count, 0);
      check("rst_divisor", divisor, 0);
      check("rst_wrap", wrap, 0);
      check("rst_active", active, 0);
      check("rst_ready", note_ready, 1);
      exp_q.delete();
      cur_exp = 0;
      tick(2);
      rst = 1'b0;
      tick(5);
      check("pending_lost_divisor", divisor, 0);
      check("pending_lost_active", active, 0);

      // Pitch change while running holds until the wrap
      send_note(9, 7, 0, 1);
      tick(3);
      send_note(9, 6, 0, 1);
      check("hold_until_wrap", divisor, model_div(9, 7, 0));

      // Back-to-back requests
      send_note(0, 7, 0, 1);
      check("b2b_ready_low", note_ready, 0);
      send_note(7, 7, 0, 1);
      check("b2b_first_applied", divisor, model_div(0, 7, 0));
      wait_ready("g7_ready");

      // Gate dropped then restored before the wrap keeps running
      wait_count(100, "regate_c100");
      gate = 1'b0;
      wait_count(200, "regate_c200");
      gate = 1'b1;
      wait_count(0, "regate_wrap");
      tick(2);
      check("regate_active", active, 1);
      check("regate_divisor", divisor, model_div(7, 7, 0));

      // Gate dropped at count 100 drains to the end of the period
      wait_count(100, "drain_c100");
      gate = 1'b0;
      exp_q.push_back(0);
      cur_exp = 0;
      tick(300);
      check("drain_active", active, 1);
      check("drain_divisor_hold", divisor, model_div(7, 7, 0));
      wait_inactive("drain_timeout");
      check("drain_idle_count", count, 0);
      check("drain_idle_divisor", divisor, 0);
      gate = 1'b1;
      tick(2);

`ifdef DETUNE_EN
      send_note(9, 3, 2, 1);
      tick(1);
      check("detune_a3_plus2", divisor, 27378);
      do_reset();
      f = -8;
`else
      f = 0;
`endif
      // Highest octave on the shortest base period
      send_note(11, 7, f, 1);
      tick(1);
      check("clamp_divisor", divisor, model_div(11, 7, f));
      check("clamp_min", divisor >= 2, 1);

      // Randomised notes, rests and gate drops
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(5, 0) == 0) n = 12 + int'($urandom_range(3, 0));
         else n = int'($urandom_range(11, 0));
         o = int'($urandom_range(7, 6));
         f = rand_fine();
         send_note(n, o, f, 1);
         if ($urandom_range(3, 0) == 0) begin
            wait_ready("rand_ready");
            if (cur_exp != 0) begin
               gate = 1'b0;
               exp_q.push_back(0);
               cur_exp = 0;
               wait_inactive("rand_drain_timeout");
               check("rand_drain_divisor", divisor, 0);
               gate = 1'b1;
               tick(2);
            end
         end
      end

      b = 0;
      while (exp_q.size() != 0 && b < 20000) begin tick(1); b++; end
      check("scoreboard_drained", exp_q.size(), 0);
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
